mem_access_unit: RTL and testbench

- Memory-stage load/store unit directly downstream of the execute datapath.
- Consumes the registered M-stage ALU result as the address and the M-stage store data.
- Drives a variable-latency req/ack data-memory bus with byte enables, and returns an extended load result as readdataM for the writeback pipeline register.
- Stalls the pipeline via stallM until the access completes; flags misaligned addresses instead of issuing them.

---
 rtl/mem_access_unit_pkg.sv | 29 ++
 rtl/mem_access_unit_load_extend.sv | 37 +++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store unit.
// Access-size codes, FSM states and the alignment rule.
package mem_access_unit_pkg;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_BU = 3'b001;
    localparam logic [2:0] MT_H  = 3'b010;
    localparam logic [2:0] MT_HU = 3'b011;
    localparam logic [2:0] MT_W  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

    // Reserved size codes fall through to the word rule.
    function automatic logic isAligned(
        input logic [2:0] memType,
        input logic [1:0] byteOff
    );
        case (memType)
            MT_B, MT_BU: isAligned = 1'b1;
            MT_H, MT_HU: isAligned = ~byteOff[0];
            default:     isAligned = (byteOff == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension.
// Purely combinational so a cache read path can share it.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  memType,
    input  logic [1:0]  byteOff,
    input  logic [31:0] rawData,
    output logic [31:0] extData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane = rawData[7:0];
        case (byteOff)
            2'd1:    byteLane = rawData[15:8];
            2'd2:    byteLane = rawData[23:16];
            2'd3:    byteLane = rawData[31:24];
            default: byteLane = rawData[7:0];
        endcase
        halfLane = byteOff[1] ? rawData[31:16] : rawData[15:0];
    end

    always_comb begin
        extData = rawData;
        case (memType)
            MT_B:    extData = {{24{byteLane[7]}}, byteLane};
            MT_BU:   extData = {24'h0, byteLane};
            MT_H:    extData = {{16{halfLane[15]}}, halfLane};
            MT_HU:   extData = {16'h0, halfLane};
            default: extData = rawData;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives the req/ack data bus,
// stalls M until the access completes, flags misalignment.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [2:0]  memtypeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic        dreq,
    output logic        dwe,
    output logic [3:0]  dbe,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    input  logic        dack,
    input  logic [31:0] drdata,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        buserrM
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    memState_t   state;
    memState_t   stateNext;
    logic [7:0]  waitCnt;
    logic        aligned;
    logic        valid;
    logic        timedOut;
    logic [3:0]  storeBe;
    logic [31:0] storeData;
    logic [31:0] loadData;

    assign aligned = isAligned(memtypeM, aluoutM[1:0]);
    assign valid   = (memreadM | memwriteM) & aligned;
    assign adelM   = memreadM & ~aligned;
    assign adesM   = memwriteM & ~aligned;
    assign stallM  = valid & (state != DONE);

    // A dack in the final counted cycle still wins over the abort.
    assign timedOut = (state == WAIT) & ~dack
                    & ((waitCnt + 8'd1) == TIMEOUT_CNT);

    always_comb begin
        storeBe   = 4'b1111;
        storeData = writedataM;
        case (memtypeM)
            MT_B, MT_BU: begin
                storeBe   = 4'b0001 << aluoutM[1:0];
                storeData = {4{writedataM[7:0]}};
            end
            MT_H, MT_HU: begin
                storeBe   = aluoutM[1] ? 4'b1100 : 4'b0011;
                storeData = {2{writedataM[15:0]}};
            end
            default: ;
        endcase
        if (!memwriteM) storeBe = 4'b1111;
    end

    load_extend uLoadExtend (
        .memType (memtypeM),
        .byteOff (aluoutM[1:0]),
        .rawData (drdata),
        .extData (loadData)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (valid) stateNext = WAIT;
            WAIT:    if (dack || timedOut) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dreq      <= 1'b0;
            dwe       <= 1'b0;
            dbe       <= 4'b0;
            daddr     <= 32'h0;
            dwdata    <= 32'h0;
            buserrM   <= 1'b0;
            readdataM <= 32'h0;
            waitCnt   <= 8'h0;
        end else begin
            buserrM <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        dreq   <= 1'b1;
                        dwe    <= memwriteM;
                        dbe    <= storeBe;
                        daddr  <= {aluoutM[31:2], 2'b00};
                        dwdata <= storeData;
                    end
                end
                WAIT: begin
                    if (dack) begin
                        dreq      <= 1'b0;
                        readdataM <= loadData;
                    end else if (timedOut) begin
                        dreq      <= 1'b0;
                        buserrM   <= 1'b1;
                        readdataM <= 32'h0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                DONE:    waitCnt <= 8'h0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout.
// Inputs change #1 after posedge; outputs sampled on negedge.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreadM;
    logic        memwriteM;
    logic [2:0]  memtypeM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        dack;
    logic [31:0] drdata;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adelM;
    logic        adesM;
    logic        buserrM;

    int total = 0;
    int bad = 0;

    int          stalls;
    int          reqs;
    logic [31:0] busAddr;
    logic [3:0]  busBe;
    logic        busWe;
    logic [31:0] busData;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .memtypeM   (memtypeM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .dreq       (dreq),
        .dwe        (dwe),
        .dbe        (dbe),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dack       (dack),
        .drdata     (drdata),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .adelM      (adelM),
        .adesM      (adesM),
        .buserrM    (buserrM)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access; dack is given in WAIT cycle number ackCycle
    // (negative = never). Returns at the negedge of the first
    // non-stalled cycle, with inputs still applied.
    task automatic runAccess(
        input  logic        rd,
        input  logic        wr,
        input  logic [2:0]  mt,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] rdata,
        input  int          ackCycle,
        output int          nStall,
        output int          nReq,
        output logic [31:0] cAddr,
        output logic [3:0]  cBe,
        output logic        cWe,
        output logic [31:0] cData
    );
        int   w;
        logic prevReq;
        logic finished;
        memreadM   = rd;
        memwriteM  = wr;
        memtypeM   = mt;
        aluoutM    = addr;
        writedataM = wd;
        drdata     = rdata;
        dack       = 1'b0;
        nStall     = 0;
        nReq       = 0;
        cAddr      = '0;
        cBe        = '0;
        cWe        = 1'b0;
        cData      = '0;
        w          = 0;
        prevReq    = 1'b0;
        finished   = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            if (dreq) begin
                dack = (w == ackCycle);
                w++;
            end else begin
                dack = 1'b0;
            end
            @(negedge clk);
            if (stallM) nStall++;
            if (dreq && !prevReq) begin
                nReq++;
                cAddr = daddr;
                cBe   = dbe;
                cWe   = dwe;
                cData = dwdata;
            end
            prevReq = dreq;
            if (!stallM) finished = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("budget", {31'd0, finished}, 32'd1);
    endtask

    task automatic releaseInputs();
        @(posedge clk);
        #1;
        memreadM  = 1'b0;
        memwriteM = 1'b0;
        dack      = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        memreadM   = 1'b0;
        memwriteM  = 1'b0;
        memtypeM   = MT_W;
        aluoutM    = 32'h0;
        writedataM = 32'h0;
        dack       = 1'b0;
        drdata     = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.dreq", {31'd0, dreq}, 32'd0);
        chk("rst.dbe", {28'd0, dbe}, 32'd0);
        chk("rst.daddr", daddr, 32'd0);
        chk("rst.readdata", readdataM, 32'd0);
        chk("rst.stall", {31'd0, stallM}, 32'd0);
        chk("rst.buserr", {31'd0, buserrM}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // sb at byte lane 2
        runAccess(1'b0, 1'b1, MT_B, 32'h1002, 32'h0000_00AB, 32'h0, 0,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("sb.stalls", 32'(stalls), 32'd2);
        chk("sb.reqs", 32'(reqs), 32'd1);
        chk("sb.daddr", busAddr, 32'h1000);
        chk("sb.dbe", {28'd0, busBe}, 32'b0100);
        chk("sb.dwe", {31'd0, busWe}, 32'd1);
        chk("sb.dwdata", busData, 32'hABAB_ABAB);
        chk("sb.doneReq", {31'd0, dreq}, 32'd0);
        releaseInputs();

        runAccess(1'b0, 1'b1, MT_W, 32'h6000, 32'hDEAD_BEEF, 32'h0, 1,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("sw.stalls", 32'(stalls), 32'd3);
        chk("sw.dbe", {28'd0, busBe}, 32'b1111);
        chk("sw.dwdata", busData, 32'hDEAD_BEEF);
        releaseInputs();

        runAccess(1'b0, 1'b1, MT_H, 32'h6002, 32'h1234_CAFE, 32'h0, 0,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("sh.dbe", {28'd0, busBe}, 32'b1100);
        chk("sh.dwdata", busData, 32'hCAFE_CAFE);
        chk("sh.daddr", busAddr, 32'h6000);
        releaseInputs();

        runAccess(1'b1, 1'b0, MT_H, 32'h2002, 32'h0, 32'h8001_1234, 0,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("lh.data", readdataM, 32'hFFFF_8001);
        chk("lh.stalls", 32'(stalls), 32'd2);
        chk("lh.dwe", {31'd0, busWe}, 32'd0);
        chk("lh.dbe", {28'd0, busBe}, 32'b1111);
        chk("lh.daddr", busAddr, 32'h2000);
        releaseInputs();

        runAccess(1'b1, 1'b0, MT_HU, 32'h2002, 32'h0, 32'h8001_1234, 0,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("lhu.data", readdataM, 32'h0000_8001);
        releaseInputs();

        // three WAIT cycles, ack in the third
        runAccess(1'b1, 1'b0, MT_B, 32'h3003, 32'h0, 32'h7F00_0000, 2,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("lb.data", readdataM, 32'h0000_007F);
        chk("lb.stalls", 32'(stalls), 32'd4);
        chk("lb.reqs", 32'(reqs), 32'd1);
        releaseInputs();

        runAccess(1'b1, 1'b0, MT_W, 32'h4002, 32'h0, 32'h5555_5555, 0,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("lwMis.adel", {31'd0, adelM}, 32'd1);
        chk("lwMis.ades", {31'd0, adesM}, 32'd0);
        chk("lwMis.stall", {31'd0, stallM}, 32'd0);
        releaseInputs();
        @(negedge clk);
        chk("lwMis.dreq", {31'd0, dreq}, 32'd0);
        chk("lwMis.hold", readdataM, 32'h0000_007F);
        @(posedge clk);
        #1;

        runAccess(1'b0, 1'b1, MT_H, 32'h4001, 32'hFFFF_FFFF, 32'h0, 0,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("shMis.ades", {31'd0, adesM}, 32'd1);
        chk("shMis.adel", {31'd0, adelM}, 32'd0);
        chk("shMis.reqs", 32'(reqs), 32'd0);
        releaseInputs();
        @(negedge clk);
        chk("shMis.dreq", {31'd0, dreq}, 32'd0);
        @(posedge clk);
        #1;

        // no dack: abort after four WAIT cycles
        runAccess(1'b1, 1'b0, MT_W, 32'h7000, 32'h0, 32'h9999_9999, -1,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("tmo.stalls", 32'(stalls), 32'd5);
        chk("tmo.buserr", {31'd0, buserrM}, 32'd1);
        chk("tmo.data", readdataM, 32'h0);
        chk("tmo.dreq", {31'd0, dreq}, 32'd0);
        releaseInputs();
        @(negedge clk);
        chk("tmo.pulse", {31'd0, buserrM}, 32'd0);
        chk("tmo.idleReq", {31'd0, dreq}, 32'd0);
        @(posedge clk);
        #1;

        // dack in the cycle the counter would expire
        runAccess(1'b1, 1'b0, MT_W, 32'h5004, 32'h0, 32'h1234_5678, 3,
                  stalls, reqs, busAddr, busBe, busWe, busData);
        chk("edge.stalls", 32'(stalls), 32'd5);
        chk("edge.buserr", {31'd0, buserrM}, 32'd0);
        chk("edge.data", readdataM, 32'h1234_5678);
        releaseInputs();

        // reset in WAIT, then a stray dack
        memreadM = 1'b1;
        memtypeM = MT_W;
        aluoutM  = 32'h5000;
        drdata   = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstw.inWait", {31'd0, dreq}, 32'd1);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        memreadM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        dack  = 1'b1;
        @(negedge clk);
        chk("rstw.dreq", {31'd0, dreq}, 32'd0);
        chk("rstw.stall", {31'd0, stallM}, 32'd0);
        chk("rstw.data", readdataM, 32'h0);
        @(posedge clk);
        #1;
        dack = 1'b0;
        @(negedge clk);
        chk("rstw.lateAck", readdataM, 32'h0);
        chk("rstw.idle", {31'd0, dreq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
